board_shuffle_sequencer: RTL and testbench

Owns the write port of the 32-square board register at game start. On a `start` pulse it fills all 32 squares with the canonical covered piece set: 16 red and 16 black pieces. It then shuffles them in place with a Fisher-Yates pass driven by an LFSR. While idle it passes the game logic's write requests straight through to the board register. It holds the game logic off while it is busy, so there is exactly one writer per cycle.

---
 rtl/board_shuffle_sequencer.sv | 121 ++++++++++++
 tb/tb_board_shuffle_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/board_shuffle_sequencer.sv
// Board write-port owner at game start: fills the 32 squares with the covered piece set,
// Fisher-Yates shuffles them with an LFSR, and passes game-logic writes through while idle.
module board_shuffle_sequencer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         start,
  input  logic [159:0] board_input,
  input  logic [4:0]   gl_addr,
  input  logic [4:0]   gl_piece,
  input  logic         gl_we,
  output logic [4:0]   board_addr,
  output logic [4:0]   board_piece,
  output logic         board_we,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, FILL, PICK, SWAP_A, SWAP_B, DONE} state_t;

  state_t           state;
  logic [4:0]       k, i, j, tmp_i, tmp_j;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [4:0]       r;
  logic [31:0][4:0] sq;

  assign sq       = board_input;
  assign r        = lfsr[4:0];
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Canonical per-colour set: 5 soldiers, 2 each of cannon..queen, 1 king.
  function automatic logic [2:0] piece_type(input logic [3:0] m);
    if      (m <= 4'd4)  piece_type = 3'd1;
    else if (m <= 4'd6)  piece_type = 3'd2;
    else if (m <= 4'd8)  piece_type = 3'd3;
    else if (m <= 4'd10) piece_type = 3'd4;
    else if (m <= 4'd12) piece_type = 3'd5;
    else if (m <= 4'd14) piece_type = 3'd6;
    else                 piece_type = 3'd7;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      k     <= 5'd0;
      i     <= 5'd31;
      j     <= 5'd0;
      tmp_i <= 5'd0;
      tmp_j <= 5'd0;
      lfsr  <= LFSR_SEED;
    end else begin
      // Free-running so the arrival time of start seeds the shuffle.
      lfsr <= lfsr_nxt;
      case (state)
        IDLE: if (start) begin
          state <= FILL;
          k     <= 5'd0;
        end
        FILL: begin
          k <= k + 5'd1;
          if (k == 5'd31) begin
            state <= PICK;
            i     <= 5'd31;
          end
        end
        PICK: if (r <= i) begin
          // Rejection sampling: out-of-range draws simply wait for the next LFSR value.
          j     <= r;
          tmp_i <= sq[i];
          tmp_j <= sq[r];
          state <= SWAP_A;
        end
        SWAP_A: state <= SWAP_B;
        SWAP_B: begin
          if (i == 5'd1) state <= DONE;
          else begin
            i     <= i - 5'd1;
            state <= PICK;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // SWAP_B writes the latched tmp_i since square i was already overwritten in SWAP_A.
  always_comb begin
    board_addr  = 5'd0;
    board_piece = 5'd0;
    board_we    = 1'b0;
    case (state)
      IDLE: begin
        board_addr  = gl_addr;
        board_piece = gl_piece;
        board_we    = gl_we;
      end
      FILL: begin
        board_addr  = k;
        board_piece = {k[4], piece_type(k[3:0]), 1'b0};
        board_we    = 1'b1;
      end
      SWAP_A: begin
        board_addr  = i;
        board_piece = tmp_j;
        board_we    = 1'b1;
      end
      SWAP_B: begin
        board_addr  = j;
        board_piece = tmp_i;
        board_we    = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_board_shuffle_sequencer.sv
// Directed bench for board_shuffle_sequencer: models the board register and the LFSR,
// and predicts every write of the fill and shuffle.
module tb_board_shuffle_sequencer;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [2:0] TYPES [16] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3,
                                        3'd3, 3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7};
  localparam int EXPCNT [8] = '{0, 5, 2, 2, 2, 2, 2, 1};

  logic         CLK = 1'b0;
  logic         RESET, start, gl_we;
  logic [4:0]   gl_addr, gl_piece;
  logic [159:0] board_input;
  logic [4:0]   board_addr, board_piece;
  logic         board_we, busy, done;

  logic [4:0]   mem [32] = '{default: 5'h00};
  logic [15:0]  m_lfsr;
  int           wr_cnt   = 0;
  int           done_cnt = 0;
  int           checks   = 0;
  int           errors   = 0;
  int           dwell1   = 0;

  always #5 CLK = ~CLK;

  board_shuffle_sequencer #(.LFSR_SEED(SEED)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .board_input(board_input),
    .gl_addr(gl_addr), .gl_piece(gl_piece), .gl_we(gl_we),
    .board_addr(board_addr), .board_piece(board_piece), .board_we(board_we),
    .busy(busy), .done(done)
  );

  for (genvar g = 0; g < 32; g++) begin : g_bi
    assign board_input[5*g +: 5] = mem[g];
  end

  // Board register, write/done monitors and the reference LFSR.
  always @(posedge CLK) begin
    if (board_we) mem[board_addr] <= board_piece;
    if (busy && board_we) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (RESET) m_lfsr <= SEED;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic drive_noise(input bit noise, input int c);
    if (noise) begin
      gl_we    = 1'b1;
      gl_addr  = 5'd7;
      gl_piece = 5'h1F;
      start    = (c % 4 == 0);
    end
  endtask

  task automatic run_shuffle(input bit noise);
    logic [4:0] exp [32];
    logic [4:0] kk, r, t;
    int w0, d0, rej, c;
    int cnt [2][8];
    w0 = wr_cnt;
    d0 = done_cnt;
    c  = 0;
    start = 1'b1;
    #1 chk("start_idle_busy", busy, 1'b0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      kk = k[4:0];
      drive_noise(noise, c++);
      exp[k] = {kk[4], TYPES[kk[3:0]], 1'b0};
      #1;
      chk("fill_we", board_we, 1'b1);
      chk("fill_addr", board_addr, kk);
      chk("fill_piece", board_piece, exp[k]);
      chk("fill_busy", busy, 1'b1);
      tick();
    end
    for (int i = 31; i >= 1; i--) begin
      rej = 0;
      forever begin
        drive_noise(noise, c++);
        #1;
        chk("pick_we", board_we, 1'b0);
        chk("pick_done", done, 1'b0);
        r = m_lfsr[4:0];
        tick();
        if (r <= i[4:0]) break;
        rej++;
        if (i == 1) dwell1++;
        if (rej > 1000) begin
          chk("pick_bound", 1'b0, 1'b1);
          $display("FAIL pick_bound PICK never accepted at i=%0d", i);
          $fatal(1);
        end
      end
      start = 1'b0;
      #1;
      chk("swapa_we", board_we, 1'b1);
      chk("swapa_addr", board_addr, i[4:0]);
      chk("swapa_piece", board_piece, exp[r]);
      tick();
      #1;
      chk("swapb_we", board_we, 1'b1);
      chk("swapb_addr", board_addr, r);
      chk("swapb_piece", board_piece, exp[i]);
      if (i == 1) chk("small_j", board_addr <= 5'd1, 1'b1);
      tick();
      t = exp[i]; exp[i] = exp[r]; exp[r] = t;
    end
    gl_we = 1'b0;
    start = 1'b0;
    #1;
    chk("done_pulse", done, 1'b1);
    chk("done_we", board_we, 1'b0);
    chk("done_busy", busy, 1'b1);
    tick();
    #1;
    chk("after_done", done, 1'b0);
    chk("after_busy", busy, 1'b0);
    chk("write_count", wr_cnt - w0, 94);
    chk("done_count", done_cnt - d0, 1);
    for (int s = 0; s < 2; s++) for (int y = 0; y < 8; y++) cnt[s][y] = 0;
    for (int s = 0; s < 32; s++) begin
      chk("board_sq", mem[s], exp[s]);
      chk("board_bit0", mem[s][0], 1'b0);
      cnt[mem[s][4]][mem[s][3:1]]++;
    end
    for (int s = 0; s < 2; s++)
      for (int y = 1; y < 8; y++) chk("type_count", cnt[s][y], EXPCNT[y]);
  endtask

  initial begin
    RESET = 1'b1; start = 1'b0; gl_we = 1'b0; gl_addr = 5'd0; gl_piece = 5'd0;
    tick();
    tick();
    RESET = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_we", board_we, 1'b0);
    gl_we = 1'b1; gl_addr = 5'd5; gl_piece = 5'h13;
    #1;
    chk("pt_we", board_we, 1'b1);
    chk("pt_addr", board_addr, 5'd5);
    chk("pt_piece", board_piece, 5'h13);
    tick();
    gl_we = 1'b0;

    // Fill spot values straight from the piece table.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      #1;
      if (k == 0)  chk("fill0", board_piece, 5'h02);
      if (k == 5)  chk("fill5", board_piece, 5'h04);
      if (k == 15) chk("fill15", board_piece, 5'h0E);
      if (k == 16) chk("fill16", board_piece, 5'h12);
      if (k == 31) chk("fill31", board_piece, 5'h1E);
      tick();
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;

    run_shuffle(1'b0);
    repeat (3) tick();
    run_shuffle(1'b1);

    // Reset in the middle of the fill.
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #1 chk("mid_addr10", board_addr, 5'd10);
    RESET = 1'b1;
    tick();
    #1;
    chk("mid_busy", busy, 1'b0);
    chk("mid_we", board_we, 1'b0);
    RESET = 1'b0;
    gl_we = 1'b1; gl_addr = 5'd3; gl_piece = 5'h0B;
    #1;
    chk("mid_pt_we", board_we, 1'b1);
    chk("mid_pt_addr", board_addr, 5'd3);
    chk("mid_pt_piece", board_piece, 5'h0B);
    tick();
    gl_we = 1'b0;
    run_shuffle(1'b0);

    $display("info: PICK dwell cycles observed at i=1: %0d", dwell1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
